fir_tap_sequencer: RTL and testbench



---
 rtl/fir_seq_pkg.sv | 26 ++
 rtl/fir_tap_sequencer_mac.sv | 38 +++
 rtl/fir_tap_sequencer.sv | 152 +++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_seq_pkg.sv
// Shared types and helpers for the time-multiplexed FIR tap sequencer.
//   state_e   : sequencer FSM state (idle, accumulate, output strobe)
//   acc_width : accumulator width that cannot overflow for a given tap count
//   sat       : clamp a value to the largest unsigned number of a given width
package fir_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StOutput
    } state_e;

    // Product is 2*width bits; summing coeff_numb of them needs clog2 extra bits.
    function automatic int unsigned acc_width(input int unsigned width,
                                              input int unsigned coeff_numb);
        return 2 * width + $clog2(coeff_numb);
    endfunction

    // Values are carried in 64 bits, so width must stay below 64.
    function automatic logic [63:0] sat(input logic [63:0] value, input int unsigned width);
        logic [63:0] max_val;
        max_val = (64'd1 << width) - 64'd1;
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/fir_tap_sequencer_mac.sv
// fir_mac: registered unsigned multiply-accumulate shared by all FIR taps.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears accumulator)
//   i_clear    : synchronous clear of the accumulator (wins over i_en)
//   i_en       : add i_a * i_b into the accumulator this edge
//   i_a, i_b   : unsigned operands, WIDTH bits each
//   o_acc      : accumulator value, ACC_W bits
module fir_mac
    import fir_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ACC_W = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [ACC_W-1:0] o_acc
);

    logic [2*WIDTH-1:0] w_prod;
    logic [ACC_W-1:0]   r_acc;

    assign w_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + ACC_W'(w_prod);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: time-multiplexed FIR controller. One shared MAC processes one tap per
// cycle; the block owns the circular sample delay line and the programmable coefficient bank.
// Optional build macro FIR_TAP_SEQUENCER_SAT_FLAG_EN adds the sat_sticky output.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   data_in, valid_in          : upstream sample and valid
//   ready_in                   : high in idle, sample accepted on valid_in && ready_in
//   coeff_we/addr/wdata        : coefficient write port, honoured only in idle
//   valid_out, data_out        : one-cycle result strobe, result held between strobes
//   busy                       : high while a sample is being processed
//   sat_sticky (optional)      : set when any output was clipped, cleared by reset
module fir_tap_sequencer
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned COEFF_NUMB = 11,
    parameter int unsigned SHIFT      = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          valid_in,
    output logic                          ready_in,
    input  logic                          coeff_we,
    input  logic [$clog2(COEFF_NUMB)-1:0] coeff_addr,
    input  logic [WIDTH-1:0]              coeff_wdata,
    output logic                          valid_out,
    output logic [WIDTH-1:0]              data_out,
    output logic                          busy
`ifdef FIR_TAP_SEQUENCER_SAT_FLAG_EN
    ,
    output logic                          sat_sticky
`endif
);

    import fir_seq_pkg::*;

    localparam int unsigned    PTR_W = $clog2(COEFF_NUMB);
    localparam int unsigned    ACC_W = acc_width(WIDTH, COEFF_NUMB);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(COEFF_NUMB - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] r_k;
    logic [WIDTH-1:0] r_x     [COEFF_NUMB];
    logic [WIDTH-1:0] r_coeff [COEFF_NUMB];
    logic [WIDTH-1:0] r_data_out;

    logic             w_accept;
    logic             w_coeff_wr;
    logic             w_mac_en;
    logic [ACC_W-1:0] w_acc;
    logic [ACC_W-1:0] w_scaled;
    logic             w_clip;
    logic [WIDTH-1:0] w_sat;

    assign w_accept   = (r_state == StIdle) && valid_in;
    assign w_coeff_wr = (r_state == StIdle) && coeff_we && (32'(coeff_addr) < COEFF_NUMB);
    assign w_mac_en   = (r_state == StAccum);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_accept) w_state_next = StAccum;
            StAccum:  if (r_k == LAST) w_state_next = StOutput;
            StOutput: w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // r_rptr starts at the newest sample and walks backwards through the circular line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_k        <= '0;
            r_data_out <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_rptr <= r_wptr;
                r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + PTR_W'(1);
                r_k    <= '0;
            end else if (r_state == StAccum) begin
                r_rptr <= (r_rptr == '0) ? LAST : r_rptr - PTR_W'(1);
                r_k    <= r_k + PTR_W'(1);
            end
            if (r_state == StOutput) begin
                r_data_out <= w_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(COEFF_NUMB); i++) begin
                r_x[i]     <= '0;
                r_coeff[i] <= WIDTH'(i + 1);
            end
        end else begin
            if (w_accept) begin
                r_x[r_wptr] <= data_in;
            end
            if (w_coeff_wr) begin
                r_coeff[coeff_addr] <= coeff_wdata;
            end
        end
    end

    fir_mac #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_accept),
        .i_en    (w_mac_en),
        .i_a     (r_coeff[r_k]),
        .i_b     (r_x[r_rptr]),
        .o_acc   (w_acc)
    );

    // Clipping is detected as "saturation changed the value".
    assign w_scaled = w_acc >> SHIFT;
    assign w_clip   = (sat(64'(w_scaled), WIDTH) != 64'(w_scaled));
    assign w_sat    = w_clip ? {WIDTH{1'b1}} : w_scaled[WIDTH-1:0];

    // The final MAC sum is registered on entry to OUTPUT, so the result is shown
    // combinationally during the strobe and held from r_data_out afterwards.
    assign valid_out = (r_state == StOutput);
    assign data_out  = (r_state == StOutput) ? w_sat : r_data_out;
    assign ready_in  = (r_state == StIdle);
    assign busy      = (r_state != StIdle);

`ifdef FIR_TAP_SEQUENCER_SAT_FLAG_EN
    logic r_sat_sticky;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sat_sticky <= 1'b0;
        end else if ((r_state == StOutput) && w_clip) begin
            r_sat_sticky <= 1'b1;
        end
    end

    // Visible together with the clipped strobe, not one cycle later.
    assign sat_sticky = r_sat_sticky | ((r_state == StOutput) && w_clip);
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer (default parameters). A reference model computes
// each expected result when a sample is accepted and pushes it to a scoreboard; a monitor pops
// and compares on every valid_out strobe.
module tb_fir_tap_sequencer;

    localparam int N = 11;
    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic [W-1:0] data_in;
    logic         valid_in;
    logic         ready_in;
    logic         coeff_we;
    logic [3:0]   coeff_addr;
    logic [W-1:0] coeff_wdata;
    logic         valid_out;
    logic [W-1:0] data_out;
    logic         busy;
`ifdef FIR_TAP_SEQUENCER_SAT_FLAG_EN
    logic         sat_sticky;
`endif

    fir_tap_sequencer #(
        .WIDTH      (W),
        .COEFF_NUMB (N),
        .SHIFT      (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .coeff_we    (coeff_we),
        .coeff_addr  (coeff_addr),
        .coeff_wdata (coeff_wdata),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .busy        (busy)
`ifdef FIR_TAP_SEQUENCER_SAT_FLAG_EN
        ,
        .sat_sticky  (sat_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [W-1:0] m_hist [N];
    logic [W-1:0] m_coef [N];
    logic         m_sat;
    logic [W-1:0] sb_data [$];
    logic         sb_clip [$];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_hist[i] = '0;
            m_coef[i] = W'(i + 1);
        end
        m_sat = 1'b0;
        sb_data.delete();
        sb_clip.delete();
    endfunction

    function automatic void push_expected(input logic [W-1:0] d);
        int unsigned sum;
        for (int i = N - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = d;
        sum = 0;
        for (int i = 0; i < N; i++) sum = sum + m_coef[i] * m_hist[i];
        sb_data.push_back((sum > 255) ? 8'd255 : sum[7:0]);
        sb_clip.push_back(sum > 255);
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic         c;
        if (!reset && valid_out) begin
            n_cmp++;
            if (sb_data.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe: valid_out=1 data_out=%0d, required no strobe",
                         data_out);
            end else begin
                e = sb_data.pop_front();
                c = sb_clip.pop_front();
                if (data_out !== e) begin
                    n_err++;
                    $display("FAIL result: data_out=%0d, required %0d", data_out, e);
                end
`ifdef FIR_TAP_SEQUENCER_SAT_FLAG_EN
                m_sat = m_sat | c;
                n_cmp++;
                if (sat_sticky !== m_sat) begin
                    n_err++;
                    $display("FAIL sat_sticky: got %b, required %b", sat_sticky, m_sat);
                end
`else
                c = 1'b0;
`endif
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        valid_in = 1'b0;
        coeff_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic send(input logic [W-1:0] d);
        int g;
        g = 0;
        while (!ready_in && g < 40) begin
            @(posedge clk);
            #1;
            g++;
        end
        n_cmp++;
        if (g >= 40) begin
            n_err++;
            $display("FAIL send_ready: ready_in=%b after 40 cycles, required 1", ready_in);
        end
        valid_in = 1'b1;
        data_in  = d;
        push_expected(d);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        while ((sb_data.size() != 0 || !ready_in) && g < 60) begin
            @(posedge clk);
            #1;
            g++;
        end
        n_cmp++;
        if (g >= 60) begin
            n_err++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb_data.size());
        end
    endtask

    task automatic write_coeff(input logic [3:0] a, input logic [W-1:0] v);
        coeff_we    = 1'b1;
        coeff_addr  = a;
        coeff_wdata = v;
        @(posedge clk);
        #1;
        coeff_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp += 4;
        if (ready_in !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b, required 1", ready_in); end
        if (valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, required 0", valid_out); end
        if (data_out !== 8'd0) begin n_err++; $display("FAIL rst_data: got %0d, required 0", data_out); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
`ifdef FIR_TAP_SEQUENCER_SAT_FLAG_EN
        n_cmp++;
        if (sat_sticky !== 1'b0) begin n_err++; $display("FAIL rst_sat: got %b, required 0", sat_sticky); end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_impulse();
        do_reset();
        send(8'd1);
        repeat (11) send(8'd0);
        wait_drain("impulse");
    endtask

    task automatic test_step();
        do_reset();
        repeat (12) send(8'd1);
        wait_drain("step");
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (data_out !== 8'd66 || valid_out !== 1'b0) begin
                n_err++;
                $display("FAIL step_hold: data_out=%0d valid_out=%b, required 66 and 0",
                         data_out, valid_out);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        do_reset();
        data_in  = 8'd1;
        valid_in = 1'b1;
        push_expected(8'd1);
        @(posedge clk);
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            n_cmp += 3;
            if (valid_out !== (i == 12)) begin
                n_err++;
                $display("FAIL lat_valid_c%0d: got %b, required %b", i, valid_out, (i == 12));
            end
            if (ready_in !== (i == 13)) begin
                n_err++;
                $display("FAIL lat_ready_c%0d: got %b, required %b", i, ready_in, (i == 13));
            end
            if (busy !== (i != 13)) begin
                n_err++;
                $display("FAIL lat_busy_c%0d: got %b, required %b", i, busy, (i != 13));
            end
            // valid_in is still high, so exactly one more sample is taken at the next edge.
            if (i == 13) push_expected(8'd1);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        wait_drain("latency");
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_saturation();
        do_reset();
        send(8'd255);
        send(8'd255);
        wait_drain("sat");
`ifdef FIR_TAP_SEQUENCER_SAT_FLAG_EN
        @(negedge clk);
        n_cmp++;
        if (sat_sticky !== 1'b1) begin n_err++; $display("FAIL sat_hold: got %b, required 1", sat_sticky); end
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic test_coeff_load();
        do_reset();
        write_coeff(4'd0, 8'h10);
        m_coef[0] = 8'h10;
        send(8'd2);
        repeat (3) @(posedge clk);
        #1;
        write_coeff(4'd1, 8'h80);   // in ACCUM: must be dropped
        wait_drain("coeff_a");
        send(8'd0);
        wait_drain("coeff_b");
        // Write coincident with accept applies to that sample.
        coeff_we    = 1'b1;
        coeff_addr  = 4'd2;
        coeff_wdata = 8'd5;
        m_coef[2]   = 8'd5;
        valid_in    = 1'b1;
        data_in     = 8'd0;
        push_expected(8'd0);
        @(posedge clk);
        #1;
        coeff_we = 1'b0;
        valid_in = 1'b0;
        wait_drain("coeff_c");
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_coeff(4'd0, 8'h10);
        m_coef[0] = 8'h10;
        send(8'd7);
        wait_drain("mid_a");
        data_in  = 8'd1;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        n_cmp += 2;
        if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b, required 0", busy); end
        if (ready_in !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b, required 1", ready_in); end
        repeat (20) @(posedge clk);
        #1;
        send(8'd1);
        send(8'd0);
        send(8'd0);
        wait_drain("mid_b");
    endtask

    initial begin
        reset       = 1'b1;
        valid_in    = 1'b0;
        data_in     = '0;
        coeff_we    = 1'b0;
        coeff_addr  = '0;
        coeff_wdata = '0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_impulse();
        test_step();
        test_latency();
        test_saturation();
        test_coeff_load();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
